strip_placement_scheduler: RTL and testbench

//  Front-end controller for the End_Part index pipeline (HRMPP). It round-robin arbitrates
//  NUM_REQ program-placement requesters and first-fit scans a private occupied-width table
//  (one entry per strip). It then drives the End_Part write-stage inputs with strip ID,
//  old/new occupied width and the strike flag/counter. A request that fits in no strip is
//  a "strike".

---
 rtl/hrmpp_pkg.sv | 19 +
 rtl/strip_placement_scheduler_if.sv | 35 +++
 rtl/strip_placement_scheduler_rr_arbiter.sv | 30 +++
 rtl/strip_placement_scheduler.sv | 149 ++++++++++++++
 tb/tb_strip_placement_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hrmpp_pkg.sv
// Shared HRMPP definitions: field widths, the scheduler state type and a
// saturating strike-count helper. The End_Part top imports the same package.
package hrmpp_pkg;

  localparam int STRIP_ID_W = 4;
  localparam int WIDTH_W    = 8;
  localparam int STRIKE_W   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Strike counter stops at all-ones instead of wrapping.
  function automatic logic [STRIKE_W-1:0] strike_inc(input logic [STRIKE_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/strip_placement_scheduler_if.sv
// Requester handshake plus End_Part write-stage bus of the placement scheduler.
interface strip_placement_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import hrmpp_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [WIDTH_W*NUM_REQ-1:0] req_width;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       busy;
  logic                       issue_valid;
  logic [2:0]                 issue_req_id;
  logic                       strike_flag_write;
  logic [STRIP_ID_W-1:0]      strip_ID_write;
  logic [WIDTH_W-1:0]         old_occupied_width_write;
  logic [WIDTH_W-1:0]         new_occupied_width_write;
  logic [STRIKE_W-1:0]        strike_counter_write;

  // Requester / observer side.
  modport master (
    output req_valid, req_width,
    input  req_ready, busy, issue_valid, issue_req_id, strike_flag_write,
           strip_ID_write, old_occupied_width_write, new_occupied_width_write,
           strike_counter_write
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_width,
    output req_ready, busy, issue_valid, issue_req_id, strike_flag_write,
           strip_ID_write, old_occupied_width_write, new_occupied_width_write,
           strike_counter_write
  );

endinterface

// File: rtl/strip_placement_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_any
);

  // Walk offsets from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((int'(ptr) + off) % NUM_REQ == i) && req[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = 3'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/strip_placement_scheduler.sv
// Round-robin request intake plus first-fit scan of a private strip-width table,
// driving the End_Part write stage. Write outputs hold between issues because
// End_Part rewrites its array every clock.
module strip_placement_scheduler
  import hrmpp_pkg::*;
#(
  parameter int                 NUM_REQ    = 4,
  parameter int                 NUM_STRIPS = 14,
  parameter logic [WIDTH_W-1:0] CAPACITY   = 8'd64
) (
  input logic                        clk,
  input logic                        rst,
  input logic                        clear_table,
  strip_placement_scheduler_if.slave bus
);

  localparam logic [STRIP_ID_W-1:0] LAST_IDX = STRIP_ID_W'(NUM_STRIPS - 1);

  state_e                state_reg;
  logic [2:0]            rr_ptr_reg;
  logic [2:0]            rr_ptr_next;
  logic [STRIP_ID_W-1:0] idx_reg;
  logic [WIDTH_W-1:0]    width_reg;
  logic [2:0]            id_reg;
  logic [WIDTH_W-1:0]    table_reg [NUM_STRIPS];
  logic [STRIKE_W-1:0]   count_reg;

  logic                  issue_valid_reg;
  logic                  flag_reg;
  logic [STRIP_ID_W-1:0] strip_reg;
  logic [WIDTH_W-1:0]    old_reg;
  logic [WIDTH_W-1:0]    new_reg;
  logic [2:0]            issue_id_reg;

  logic [WIDTH_W-1:0]    req_width_arr [NUM_REQ];
  logic [WIDTH_W-1:0]    sel_width;
  logic [NUM_REQ-1:0]    grant;
  logic [2:0]            grant_idx;
  logic                  grant_any;
  logic [WIDTH_W:0]      sum9;
  logic                  fit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_width_arr[gi] = bus.req_width[WIDTH_W*gi +: WIDTH_W];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Width of the granted requester and the pointer position just past it.
  always_comb begin
    sel_width = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) sel_width = req_width_arr[i];
    end
    rr_ptr_next = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  // Fit test at 9 bits so an oversize sum cannot wrap into range.
  assign sum9 = {1'b0, table_reg[idx_reg]} + {1'b0, width_reg};
  assign fit  = (width_reg != '0) && (sum9 <= {1'b0, CAPACITY});

  assign bus.req_ready = (state_reg == IDLE && !rst && !clear_table) ? grant : '0;
  assign bus.busy                     = (state_reg == SCAN);
  assign bus.issue_valid              = issue_valid_reg;
  assign bus.issue_req_id             = issue_id_reg;
  assign bus.strike_flag_write        = flag_reg;
  assign bus.strip_ID_write           = strip_reg;
  assign bus.old_occupied_width_write = old_reg;
  assign bus.new_occupied_width_write = new_reg;
  assign bus.strike_counter_write     = count_reg;

  // Intake, strip scan, table update and write-stage output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      idx_reg         <= '0;
      width_reg       <= '0;
      id_reg          <= '0;
      count_reg       <= '0;
      issue_valid_reg <= 1'b0;
      flag_reg        <= 1'b0;
      strip_reg       <= '0;
      old_reg         <= '0;
      new_reg         <= '0;
      issue_id_reg    <= '0;
      for (int i = 0; i < NUM_STRIPS; i++) table_reg[i] <= '0;
    end else if (clear_table) begin
      // Any in-flight scan is dropped; outputs point at an empty strip 0.
      state_reg       <= IDLE;
      idx_reg         <= '0;
      count_reg       <= '0;
      issue_valid_reg <= 1'b0;
      flag_reg        <= 1'b0;
      strip_reg       <= '0;
      old_reg         <= '0;
      new_reg         <= '0;
      for (int i = 0; i < NUM_STRIPS; i++) table_reg[i] <= '0;
    end else begin
      issue_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            width_reg  <= sel_width;
            id_reg     <= grant_idx;
            rr_ptr_reg <= rr_ptr_next;
            idx_reg    <= '0;
            state_reg  <= SCAN;
          end
        end
        SCAN: begin
          if (fit) begin
            old_reg            <= table_reg[idx_reg];
            new_reg            <= sum9[WIDTH_W-1:0];
            strip_reg          <= idx_reg;
            flag_reg           <= 1'b0;
            table_reg[idx_reg] <= sum9[WIDTH_W-1:0];
            issue_id_reg       <= id_reg;
            issue_valid_reg    <= 1'b1;
            state_reg          <= IDLE;
          end else if (idx_reg != LAST_IDX) begin
            idx_reg <= idx_reg + 1'b1;
          end else begin
            // Strike: rewrite strip 0 with its own width so the write is harmless.
            old_reg         <= table_reg[0];
            new_reg         <= table_reg[0];
            strip_reg       <= '0;
            flag_reg        <= 1'b1;
            count_reg       <= strike_inc(count_reg);
            issue_id_reg    <= id_reg;
            issue_valid_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_placement_scheduler.sv
// Directed and random checks of strip_placement_scheduler against a
// transaction-level model of the strip table.
module tb_strip_placement_scheduler;

  localparam int NR = 4;
  localparam int NS = 14;
  localparam int CAP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_table = 1'b0;

  int tests = 0;
  int fails = 0;

  strip_placement_scheduler_if #(.NUM_REQ(NR)) bus ();

  strip_placement_scheduler #(.NUM_REQ(NR), .NUM_STRIPS(NS), .CAPACITY(8'd64)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_table (clear_table),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model: placement rules on a table of integers ----------
  int  m_table [NS];
  int  m_ptr = 0;
  int  m_count = 0;
  bit  m_pending = 0;
  int  m_cd = 0;
  int  r_id, r_flag, r_strip, r_old, r_new;
  int  e_issue = 0, e_id = 0, e_flag = 0, e_strip = 0, e_old = 0, e_new = 0;

  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int off = 0; off < NR; off++)
      if (v[(ptr + off) % NR]) return (ptr + off) % NR;
    return -1;
  endfunction

  initial for (int s = 0; s < NS; s++) m_table[s] = 0;

  // Compare DUT against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    int g, w, k;
    logic [NR-1:0] exp_ready;
    g = rr_pick(bus.req_valid, m_ptr);
    exp_ready = '0;
    if (!rst && !clear_table && !m_pending && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", int'(bus.req_ready), int'(exp_ready));
    chk("busy", int'(bus.busy), int'(m_pending));
    chk("issue_valid", int'(bus.issue_valid), e_issue);
    chk("issue_req_id", int'(bus.issue_req_id), e_id);
    chk("strike_flag", int'(bus.strike_flag_write), e_flag);
    chk("strip_id", int'(bus.strip_ID_write), e_strip);
    chk("old_width", int'(bus.old_occupied_width_write), e_old);
    chk("new_width", int'(bus.new_occupied_width_write), e_new);
    chk("strike_count", int'(bus.strike_counter_write), m_count);
    if (bus.issue_valid) chk("new_le_cap", int'(bus.new_occupied_width_write <= CAP), 1);

    if (rst) begin
      for (int s = 0; s < NS; s++) m_table[s] = 0;
      m_ptr = 0; m_count = 0; m_pending = 0;
      e_issue = 0; e_id = 0; e_flag = 0; e_strip = 0; e_old = 0; e_new = 0;
    end else if (clear_table) begin
      for (int s = 0; s < NS; s++) m_table[s] = 0;
      m_count = 0; m_pending = 0;
      e_issue = 0; e_flag = 0; e_strip = 0; e_old = 0; e_new = 0;
    end else begin
      e_issue = 0;
      if (m_pending) begin
        m_cd--;
        if (m_cd == 0) begin
          m_pending = 0;
          e_issue = 1; e_id = r_id; e_flag = r_flag; e_strip = r_strip;
          e_old = r_old; e_new = r_new;
          if (r_flag) m_count = (m_count < 15) ? m_count + 1 : 15;
          else m_table[r_strip] = r_new;
        end
      end else if (g >= 0) begin
        w = int'(bus.req_width[8*g +: 8]);
        k = -1;
        for (int s = 0; s < NS; s++)
          if (k < 0 && w != 0 && m_table[s] + w <= CAP) k = s;
        r_id = g;
        if (k >= 0) begin
          r_flag = 0; r_strip = k; r_old = m_table[k]; r_new = m_table[k] + w; m_cd = k + 1;
        end else begin
          r_flag = 1; r_strip = 0; r_old = m_table[0]; r_new = m_table[0]; m_cd = NS;
        end
        m_pending = 1;
        m_ptr = (g + 1) % NR;
      end
    end
  end

  // ---------------- directed helpers ----------------------------------------
  // Present one request, drop it on acceptance, return when issue_valid is seen.
  // lat = number of edges from the accepting edge to the edge that raised issue_valid.
  task automatic request(input int r, input int w, output int lat);
    bit got;
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b1;
    bus.req_width[8*r +: 8] = 8'(w);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) got = 1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.issue_valid) got = 1;
    end
    if (!got) chk("issue_timeout", 0, 1);
    lat = lat - 1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_table = 1'b1;
    @(posedge clk); #1 clear_table = 1'b0;
  endtask

  initial begin
    int lat, n, issues;
    int order [5];
    bus.req_valid = '0;
    bus.req_width = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("t0_strip", int'(bus.strip_ID_write), 0);
    chk("t0_count", int'(bus.strike_counter_write), 0);
    chk("t0_busy", int'(bus.busy), 0);

    // 1: single request lands in strip 0 after one scan cycle.
    request(0, 20, lat);
    chk("t1_lat", lat, 1);
    chk("t1_strip", int'(bus.strip_ID_write), 0);
    chk("t1_old", int'(bus.old_occupied_width_write), 0);
    chk("t1_new", int'(bus.new_occupied_width_write), 20);
    chk("t1_flag", int'(bus.strike_flag_write), 0);

    // 2: 40 then 30 on a clean table; the second spills into strip 1.
    pulse_clear();
    request(0, 40, lat);
    chk("t2a_new", int'(bus.new_occupied_width_write), 40);
    request(0, 30, lat);
    chk("t2b_lat", lat, 2);
    chk("t2b_strip", int'(bus.strip_ID_write), 1);
    chk("t2b_old", int'(bus.old_occupied_width_write), 0);
    chk("t2b_new", int'(bus.new_occupied_width_write), 30);

    // 3: oversize request strikes after a full scan; counter saturates at 15.
    request(0, 65, lat);
    chk("t3_lat", lat, 14);
    chk("t3_flag", int'(bus.strike_flag_write), 1);
    chk("t3_strip", int'(bus.strip_ID_write), 0);
    chk("t3_old", int'(bus.old_occupied_width_write), 40);
    chk("t3_new", int'(bus.new_occupied_width_write), 40);
    chk("t3_count", int'(bus.strike_counter_write), 1);
    for (int i = 0; i < 16; i++) request(i % NR, (i % 2 == 0) ? 0 : 70, lat);
    chk("t3_sat", int'(bus.strike_counter_write), 15);

    // 5: clear mid-scan drops the request and zeroes the write outputs.
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1;
    bus.req_width[15:8] = 8'd65;
    n = 0;
    while (!bus.req_ready[1] && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    pulse_clear();
    issues = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.issue_valid) issues++;
    end
    chk("t5_no_issue", issues, 0);
    chk("t5_strip", int'(bus.strip_ID_write), 0);
    chk("t5_old", int'(bus.old_occupied_width_write), 0);
    chk("t5_new", int'(bus.new_occupied_width_write), 0);
    chk("t5_count", int'(bus.strike_counter_write), 0);
    request(2, 10, lat);
    chk("t5b_strip", int'(bus.strip_ID_write), 0);
    chk("t5b_new", int'(bus.new_occupied_width_write), 10);
    chk("t5b_id", int'(bus.issue_req_id), 2);

    // 4: after reset, all four requesters continuously valid with width 1.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.req_width = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.req_valid = 4'hF;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++)
        if (bus.req_ready[r] && n < 5) begin order[n] = r; n++; end
    end
    @(posedge clk); #1 bus.req_valid = '0;
    chk("t4_grants", n, 5);
    chk("t4_g0", order[0], 0);
    chk("t4_g1", order[1], 1);
    chk("t4_g2", order[2], 2);
    chk("t4_g3", order[3], 3);
    chk("t4_g4", order[4], 0);
    repeat (5) @(posedge clk);

    // 6: random valids and widths 0..70 with occasional clears.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) bus.req_width[8*r +: 8] = 8'($urandom_range(0, 70));
      clear_table = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    clear_table = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
